mmr_axil_read_ctrl: RTL
=======================

Name: mmr_axil_read_ctrl

Overview:
- AXI4-Lite read-channel slave that serves host reads from the block's memory-mapped status register bank, carried on the mmr_read_interface master modport.
- Sequences one read at a time and rejects out-of-range or misaligned addresses.
- Gives coherent 64-bit reads of configured low/high register pairs through a shadow snapshot.
- Emits a one-cycle read strobe so producers can implement clear-on-read registers.

Parameters:
- NREGS, 16, number of 32-bit registers on the mmr_read_interface (>=2).
- ADDR_WIDTH, 12, width of s_axil_araddr; must satisfy 2^ADDR_WIDTH >= 4*NREGS.
- SNAP_BASE, 0, first register index of the 64-bit pair region; must be even.
- SNAP_PAIRS, 0, number of 64-bit pairs starting at SNAP_BASE; 0 disables snapshots. Requires SNAP_BASE+2*SNAP_PAIRS <= NREGS.

Ports:
- clock  input  1  sole clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- mmr  interface  mmr_read_interface.master #(NREGS)  register data array, live values.
- s_axil_araddr  input  ADDR_WIDTH  read byte address.
- s_axil_arvalid  input  1  address valid.
- s_axil_arready  output  1  address ready.
- s_axil_rdata  output  32  read data.
- s_axil_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
- s_axil_rvalid  output  1  read data valid.
- s_axil_rready  input  1  read data ready.
- rd_strobe  output  1  one-cycle pulse per successful read.
- rd_index  output  $clog2(NREGS)  index of the register read; valid while rd_strobe=1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE.
  - arready=0 while reset is high, arready=1 from the first clock after release.
  - rvalid=0, rdata=0, rresp=0, rd_strobe=0, rd_index=0.
  - All snapshot shadows cleared; snapshot-valid flags cleared.
- FSM states are IDLE and RESP.
  - IDLE: arready=1. On arvalid&arready, decode and register the response, then go to RESP.
  - RESP: arready=0, rvalid=1. rdata and rresp are held stable until rready. On rvalid&rready, go to IDLE.
- Timing and throughput:
  - AR handshake in cycle N gives rvalid=1 in cycle N+1.
  - The earliest next AR handshake is in the cycle after the R handshake, so peak throughput is one read per 2 cycles.
  - At most one read is outstanding.
- Decode:
  - idx = araddr[ADDR_WIDTH-1:2].
  - Error if araddr[1:0]!=0 or idx>=NREGS. An error returns rresp=SLVERR and rdata=0, with no strobe and no snapshot effect.
  - Otherwise rresp=OKAY.
- Data source, sampled in the handshake cycle N:
  - Default: mmr.data[idx].
  - Pair p, low register L=SNAP_BASE+2p:
    - rdata = mmr.data[L].
    - shadow[p] <= mmr.data[L+1], sampled in the same cycle.
    - snap_valid[p] <= 1.
  - Pair p, high register H=L+1:
    - If snap_valid[p]=1: rdata = shadow[p], then snap_valid[p] <= 0.
    - Otherwise rdata = mmr.data[H], i.e. the live value.
  - A second low read before the high read overwrites the shadow with a fresh sample.
- rd_strobe / rd_index:
  - rd_strobe=1 for exactly cycle N+1 on every OKAY read, including snapshot-served high reads.
  - rd_index = idx.
  - The strobe does not repeat while RESP stalls on rready=0.
- Stall: rdata and rresp do not change while the bank's live data changes during RESP.
- AR held valid during RESP: it is not accepted until IDLE. arvalid dropping without a handshake has no effect.
- Reset mid-operation (in RESP): rvalid drops immediately and asynchronously. The pending response is discarded and the snapshots are cleared.

Test Plan:
- Reset, then NREGS=16 with data[3]=32'hDEADBEEF; read 0x00C -> arready=1 the cycle after reset release; rvalid one cycle after AR; rdata=DEADBEEF, rresp=00; rd_strobe=1 for one cycle with rd_index=3.
- Read 0x040 (idx 16) and then 0x006 (misaligned) -> both return rresp=10, rdata=0, rd_strobe never asserted.
- SNAP_BASE=4, SNAP_PAIRS=1:
  - Read 0x010 while data[5]=32'h1 -> low read returns data[4].
  - Set data[5]=32'h2, then read 0x014 -> returns 32'h1.
  - Read 0x014 again -> returns live 32'h2.
- Hold rready=0 for 5 cycles while data[3] changes -> rdata stays at the first sample; rvalid stays 1; rd_strobe pulses only once; arready stays 0.
- Issue back-to-back AR with rready tied 1 -> AR handshakes every 2 cycles, rvalid alternates 1/0, data matches each address.
- SNAP_BASE=4, SNAP_PAIRS=1: read low 0x010, assert reset for 1 cycle, then read high 0x014 -> rvalid falls immediately at reset assert; after release the high read returns live data[5], because the snapshot was cleared.

Source files
------------

// File: rtl/mmr_read_interface.sv
// Register bank view shared between a block's status registers and its
// host read controller. The controller side (master) only samples the live
// values; the register owner (slave) drives them.
interface mmr_read_interface #(
  parameter int NREGS = 16
);
  logic [31:0] data [NREGS];

  modport master (input data);
  modport slave (output data);
endinterface

// File: rtl/mmr_axil_read_ctrl.sv
// AXI4-Lite read-channel slave for a memory-mapped status register bank.
// Serves one read at a time: AR handshake in IDLE registers the whole
// response (data, resp, strobe), RESP holds it stable until the host takes it.
// Misaligned or out-of-range addresses answer SLVERR with zero data.
// Configured low/high register pairs read coherently: reading the low word
// snapshots the high word into a per-pair shadow, and the next high read is
// served from that shadow instead of the live register.
module mmr_axil_read_ctrl #(
  parameter int NREGS      = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int SNAP_BASE  = 0,
  parameter int SNAP_PAIRS = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  mmr_read_interface.master        mmr,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic                     rd_strobe,
  output logic [$clog2(NREGS)-1:0] rd_index
);

  localparam int IDX_W    = $clog2(NREGS);
  localparam int WIDX_W   = ADDR_WIDTH - 2;
  // Keep the shadow storage at least one entry deep so a design without
  // snapshot pairs still elaborates; the decode never selects it then.
  localparam int SHADOW_N = (SNAP_PAIRS > 0) ? SNAP_PAIRS : 1;
  localparam int PAIR_W   = (SHADOW_N > 1) ? $clog2(SHADOW_N) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                state_q, state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic [IDX_W-1:0]    rd_index_q, rd_index_d;
  logic [31:0]         shadow_q [SHADOW_N];
  logic [31:0]         shadow_d [SHADOW_N];
  logic [SHADOW_N-1:0] snap_valid_q, snap_valid_d;

  logic [WIDX_W-1:0]   word_idx;
  logic [IDX_W-1:0]    reg_idx;
  logic                addr_err;
  int                  rel;
  logic                in_snap;
  logic                snap_high;
  logic [PAIR_W-1:0]   pair_idx;
  logic                ar_hs;

  // Address decode: word index, error detection and snapshot-pair lookup.
  always_comb begin
    word_idx  = s_axil_araddr[ADDR_WIDTH-1:2];
    reg_idx   = IDX_W'(word_idx);
    addr_err  = (s_axil_araddr[1:0] != 2'b00) || (int'(word_idx) >= NREGS);
    rel       = int'(word_idx) - SNAP_BASE;
    in_snap   = (SNAP_PAIRS > 0) && (rel >= 0) && (rel < 2 * SNAP_PAIRS);
    snap_high = rel[0];
    pair_idx  = PAIR_W'(rel >>> 1);
    ar_hs     = (state_q == ST_IDLE) && arready_q && s_axil_arvalid;
  end

  // Next-state logic: accept an address in IDLE and build the full response,
  // then hold it in RESP until the host accepts the data beat.
  always_comb begin
    state_d      = state_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rd_strobe_d  = 1'b0;
    rd_index_d   = rd_index_q;
    shadow_d     = shadow_q;
    snap_valid_d = snap_valid_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          state_d   = ST_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          if (addr_err) begin
            rdata_d = 32'h0;
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d     = RESP_OKAY;
            rd_strobe_d = 1'b1;
            rd_index_d  = reg_idx;
            rdata_d     = mmr.data[reg_idx];
            if (in_snap) begin
              if (!snap_high) begin
                shadow_d[pair_idx]     = mmr.data[reg_idx + IDX_W'(1)];
                snap_valid_d[pair_idx] = 1'b1;
              end else if (snap_valid_q[pair_idx]) begin
                rdata_d                = shadow_q[pair_idx];
                snap_valid_d[pair_idx] = 1'b0;
              end
            end
          end
        end
      end
      ST_RESP: begin
        arready_d = 1'b0;
        if (s_axil_rready) begin
          state_d   = ST_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any pending response and all snapshots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      rresp_q      <= 2'b00;
      rd_strobe_q  <= 1'b0;
      rd_index_q   <= '0;
      snap_valid_q <= '0;
      for (int i = 0; i < SHADOW_N; i++) begin
        shadow_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rd_strobe_q  <= rd_strobe_d;
      rd_index_q   <= rd_index_d;
      snap_valid_q <= snap_valid_d;
      shadow_q     <= shadow_d;
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign rd_strobe      = rd_strobe_q;
  assign rd_index       = rd_index_q;

endmodule
